// File: rtl/axis_prj_arbiter_pkg.sv
// Shared types for the project stream arbiter.
// State encoding plus the grant index width helper.
package axis_prj_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_prj_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... (mod pN) and returns the first requester.
module axis_prj_arbiter_rr_pick
  import axis_prj_arbiter_pkg::*;
#(
  parameter int pN = 4,
  parameter int pW = grant_w(pN)
) (
  input  logic [pN-1:0] i_req,
  input  logic [pW-1:0] i_last,
  output logic [pW-1:0] o_grant,
  output logic          o_valid
);

  int          w_idx;
  logic [pW-1:0] w_sel;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int k = pN; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % pN;
      w_sel = pW'(w_idx);
      if (i_req[w_sel]) begin
        o_grant = w_sel;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_prj_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter.
// One source is locked per packet; a single output register decouples upstream.
module axis_prj_arbiter
  import axis_prj_arbiter_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pNUM_PRJ    = 4,
  parameter int pID_WIDTH   = 3,
  parameter int pSTRB_WIDTH = 4
) (
  input  logic                             ASCLK,
  input  logic                             ARESET,
  input  logic [pNUM_PRJ-1:0]              prj_en_mask,
  input  logic [pNUM_PRJ-1:0]              sm_tvalid,
  input  logic [pNUM_PRJ*pDATA_WIDTH-1:0]  sm_tdata,
  input  logic [pNUM_PRJ*pSTRB_WIDTH-1:0]  sm_tstrb,
  input  logic [pNUM_PRJ-1:0]              sm_tkeep,
  input  logic [pNUM_PRJ-1:0]              sm_tlast,
  input  logic [pNUM_PRJ*pID_WIDTH-1:0]    sm_tid,
  output logic [pNUM_PRJ-1:0]              sm_tready,
  output logic                             a_sm_tvalid,
  output logic [pDATA_WIDTH-1:0]           a_sm_tdata,
  output logic [pSTRB_WIDTH-1:0]           a_sm_tstrb,
  output logic                             a_sm_tkeep,
  output logic                             a_sm_tlast,
  output logic [pID_WIDTH-1:0]             a_sm_tid,
  input  logic                             a_sm_tready,
  output logic [grant_w(pNUM_PRJ)-1:0]     cur_grant,
  output logic                             arb_busy
);

  localparam int GW = grant_w(pNUM_PRJ);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [GW-1:0]           r_grant;
  logic                    w_grant_ld;

  logic                    r_tvalid;
  logic [pDATA_WIDTH-1:0]  r_tdata;
  logic [pSTRB_WIDTH-1:0]  r_tstrb;
  logic                    r_tkeep;
  logic                    r_tlast;
  logic [pID_WIDTH-1:0]    r_tid;

  logic [pNUM_PRJ-1:0]     w_req;
  logic [GW-1:0]           w_pick;
  logic                    w_pick_vld;
  logic                    w_out_ready;
  logic                    w_accept;
  logic                    w_g_last;

  assign w_req       = sm_tvalid & prj_en_mask;
  assign w_out_ready = !r_tvalid | a_sm_tready;
  assign w_g_last    = sm_tlast[r_grant];
  assign w_accept    = (r_state == BUSY) &
                       sm_tvalid[r_grant] & w_out_ready;

  axis_prj_arbiter_rr_pick #(
    .pN (pNUM_PRJ),
    .pW (GW)
  ) u_pick (
    .i_req   (w_req),
    .i_last  (r_grant),
    .o_grant (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ld  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = BUSY;
          w_grant_ld  = 1'b1;
        end
      end
      BUSY: begin
        if (w_accept && w_g_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Only the locked source is ever offered ready.
  always_comb begin
    sm_tready = '0;
    if (r_state == BUSY) begin
      sm_tready[r_grant] = w_out_ready;
    end
  end

  always_ff @(posedge ASCLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= IDLE;
      r_grant  <= GW'(pNUM_PRJ - 1);
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tkeep  <= 1'b0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_ld) begin
        r_grant <= w_pick;
      end
      if (w_accept) begin
        r_tvalid <= 1'b1;
        r_tdata  <= sm_tdata[r_grant*pDATA_WIDTH +: pDATA_WIDTH];
        r_tstrb  <= sm_tstrb[r_grant*pSTRB_WIDTH +: pSTRB_WIDTH];
        r_tkeep  <= sm_tkeep[r_grant];
        r_tlast  <= sm_tlast[r_grant];
        r_tid    <= sm_tid[r_grant*pID_WIDTH +: pID_WIDTH];
      end else if (a_sm_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign a_sm_tvalid = r_tvalid;
  assign a_sm_tdata  = r_tdata;
  assign a_sm_tstrb  = r_tstrb;
  assign a_sm_tkeep  = r_tkeep;
  assign a_sm_tlast  = r_tlast;
  assign a_sm_tid    = r_tid;
  assign cur_grant   = r_grant;
  assign arb_busy    = (r_state == BUSY);

endmodule

// File: tb/tb_axis_prj_arbiter.sv
// Directed bench for axis_prj_arbiter.
// Sources are fed from per-source beat queues; upstream beats are logged.
module tb_axis_prj_arbiter;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int IW = 3;
  localparam int SW = 4;

  logic            ASCLK = 1'b0;
  logic            ARESET;
  logic [NP-1:0]   prj_en_mask;
  logic [NP-1:0]   sm_tvalid;
  logic [NP*DW-1:0] sm_tdata;
  logic [NP*SW-1:0] sm_tstrb;
  logic [NP-1:0]   sm_tkeep;
  logic [NP-1:0]   sm_tlast;
  logic [NP*IW-1:0] sm_tid;
  logic [NP-1:0]   sm_tready;
  logic            a_sm_tvalid;
  logic [DW-1:0]   a_sm_tdata;
  logic [SW-1:0]   a_sm_tstrb;
  logic            a_sm_tkeep;
  logic            a_sm_tlast;
  logic [IW-1:0]   a_sm_tid;
  logic            a_sm_tready;
  logic [1:0]      cur_grant;
  logic            arb_busy;

  always #5 ASCLK = ~ASCLK;

  axis_prj_arbiter #(
    .pDATA_WIDTH (DW),
    .pNUM_PRJ    (NP),
    .pID_WIDTH   (IW),
    .pSTRB_WIDTH (SW)
  ) dut (
    .ASCLK       (ASCLK),
    .ARESET      (ARESET),
    .prj_en_mask (prj_en_mask),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tstrb    (sm_tstrb),
    .sm_tkeep    (sm_tkeep),
    .sm_tlast    (sm_tlast),
    .sm_tid      (sm_tid),
    .sm_tready   (sm_tready),
    .a_sm_tvalid (a_sm_tvalid),
    .a_sm_tdata  (a_sm_tdata),
    .a_sm_tstrb  (a_sm_tstrb),
    .a_sm_tkeep  (a_sm_tkeep),
    .a_sm_tlast  (a_sm_tlast),
    .a_sm_tid    (a_sm_tid),
    .a_sm_tready (a_sm_tready),
    .cur_grant   (cur_grant),
    .arb_busy    (arb_busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [2:0]  id;
    logic [31:0] cyc;
  } obs_t;

  beat_t q[NP][$];
  bit    hold[NP];
  obs_t  olog[$];
  int    cyc_n  = 0;
  int    pass_n = 0;
  int    tot_n  = 0;

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0 && !hold[i]) begin
        sm_tvalid[i]          = 1'b1;
        sm_tdata[i*DW +: DW]  = q[i][0].d;
        sm_tlast[i]           = q[i][0].l;
      end else begin
        sm_tvalid[i]          = 1'b0;
        sm_tdata[i*DW +: DW]  = '0;
        sm_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic tick();
    logic [NP-1:0] acc;
    obs_t o;
    acc = sm_tvalid & sm_tready;
    if (a_sm_tvalid && a_sm_tready) begin
      o.d   = a_sm_tdata;
      o.l   = a_sm_tlast;
      o.id  = a_sm_tid;
      o.cyc = 32'(cyc_n);
      olog.push_back(o);
    end
    @(posedge ASCLK);
    cyc_n++;
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) void'(q[i].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic add_pkt(input int src, input int n, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = 32'(base + k);
      b.l = (k == n - 1);
      q[src].push_back(b);
    end
  endtask

  task automatic do_reset();
    ARESET      = 1'b1;
    a_sm_tready = 1'b1;
    prj_en_mask = '1;
    sm_tstrb    = '1;
    sm_tkeep    = '1;
    for (int i = 0; i < NP; i++) begin
      q[i].delete();
      hold[i] = 1'b0;
      sm_tid[i*IW +: IW] = IW'(i);
    end
    olog.delete();
    drive();
    repeat (2) @(posedge ASCLK);
    #1;
    ARESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tot_n++;
    if (a_sm_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%0b exp=0", a_sm_tvalid);
    else pass_n++;
    tot_n++;
    if (a_sm_tdata !== 32'h0) $display("FAIL rst_tdata got=%h exp=0", a_sm_tdata);
    else pass_n++;
    tot_n++;
    if (sm_tready !== 4'b0) $display("FAIL rst_tready got=%b exp=0000", sm_tready);
    else pass_n++;
    tot_n++;
    if (cur_grant !== 2'd3) $display("FAIL rst_grant got=%0d exp=3", cur_grant);
    else pass_n++;
    tot_n++;
    if (arb_busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", arb_busy);
    else pass_n++;
    repeat (3) tick();
    tot_n++;
    if (arb_busy !== 1'b0 || a_sm_tvalid !== 1'b0)
      $display("FAIL idle_noreq got busy=%0b tvalid=%0b exp=0/0", arb_busy, a_sm_tvalid);
    else pass_n++;
  endtask

  task automatic test_single();
    do_reset();
    add_pkt(0, 3, 'hA0);
    settle();
    tick();
    tot_n++;
    if (a_sm_tvalid !== 1'b0 || arb_busy !== 1'b1 || cur_grant !== 2'd0)
      $display("FAIL single_arb got v=%0b busy=%0b g=%0d exp=0/1/0",
               a_sm_tvalid, arb_busy, cur_grant);
    else pass_n++;
    tick();
    tot_n++;
    if (a_sm_tvalid !== 1'b1 || a_sm_tdata !== 32'hA0)
      $display("FAIL single_b0 got v=%0b d=%h exp=1/a0", a_sm_tvalid, a_sm_tdata);
    else pass_n++;
    tick();
    tot_n++;
    if (a_sm_tvalid !== 1'b1 || a_sm_tdata !== 32'hA1 || a_sm_tlast !== 1'b0)
      $display("FAIL single_b1 got v=%0b d=%h l=%0b exp=1/a1/0",
               a_sm_tvalid, a_sm_tdata, a_sm_tlast);
    else pass_n++;
    tick();
    tot_n++;
    if (a_sm_tdata !== 32'hA2 || a_sm_tlast !== 1'b1 || arb_busy !== 1'b0)
      $display("FAIL single_b2 got d=%h l=%0b busy=%0b exp=a2/1/0",
               a_sm_tdata, a_sm_tlast, arb_busy);
    else pass_n++;
    tick();
    tot_n++;
    if (a_sm_tvalid !== 1'b0 || cur_grant !== 2'd0 || olog.size() != 3)
      $display("FAIL single_end got v=%0b g=%0d n=%0d exp=0/0/3",
               a_sm_tvalid, cur_grant, olog.size());
    else pass_n++;
  endtask

  task automatic test_contention();
    logic [31:0] exp_d[10];
    exp_d = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20,
              32'h21, 32'h30, 32'h31, 32'h02, 32'h03};
    do_reset();
    for (int i = 0; i < NP; i++) add_pkt(i, 2, i * 16);
    add_pkt(0, 2, 2);
    settle();
    for (int c = 0; c < 80 && olog.size() < 10; c++) tick();
    tot_n++;
    if (olog.size() != 10) $display("FAIL cont_count got=%0d exp=10", olog.size());
    else pass_n++;
    for (int k = 0; k < 10 && k < olog.size(); k++) begin
      tot_n++;
      if (olog[k].d !== exp_d[k] || olog[k].l !== (k % 2 == 1) ||
          olog[k].id !== 3'(exp_d[k] >> 4))
        $display("FAIL cont_beat%0d got d=%h l=%0b id=%0d exp d=%h l=%0b",
                 k, olog[k].d, olog[k].l, olog[k].id, exp_d[k], (k % 2 == 1));
      else pass_n++;
      if (k > 0) begin
        tot_n++;
        if (olog[k].cyc - olog[k-1].cyc !== ((k % 2 == 1) ? 32'd1 : 32'd2))
          $display("FAIL cont_gap%0d got=%0d exp=%0d", k,
                   olog[k].cyc - olog[k-1].cyc, (k % 2 == 1) ? 1 : 2);
        else pass_n++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prev_d;
    bit          stalled;
    int          n_stall;
    prev_d  = '0;
    stalled = 1'b0;
    n_stall = 0;
    do_reset();
    add_pkt(2, 4, 'h20);
    settle();
    for (int c = 0; c < 16; c++) begin
      a_sm_tready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      settle();
      if (a_sm_tvalid && !a_sm_tready) begin
        n_stall++;
        tot_n++;
        if (sm_tready[2] !== 1'b0)
          $display("FAIL bp_ready c=%0d got=%0b exp=0", c, sm_tready[2]);
        else pass_n++;
        if (stalled) begin
          tot_n++;
          if (a_sm_tdata !== prev_d)
            $display("FAIL bp_stable c=%0d got=%h exp=%h", c, a_sm_tdata, prev_d);
          else pass_n++;
        end
        stalled = 1'b1;
        prev_d  = a_sm_tdata;
      end else begin
        stalled = 1'b0;
      end
      tick();
    end
    a_sm_tready = 1'b1;
    tot_n++;
    if (n_stall != 2) $display("FAIL bp_stalls got=%0d exp=2", n_stall);
    else pass_n++;
    tot_n++;
    if (olog.size() != 4) $display("FAIL bp_count got=%0d exp=4", olog.size());
    else pass_n++;
    for (int k = 0; k < 4 && k < olog.size(); k++) begin
      tot_n++;
      if (olog[k].d !== 32'(32'h20 + k) || olog[k].l !== (k == 3))
        $display("FAIL bp_beat%0d got d=%h l=%0b exp d=%h l=%0b",
                 k, olog[k].d, olog[k].l, 32'h20 + k, (k == 3));
      else pass_n++;
    end
  endtask

  task automatic test_mask();
    logic [31:0] exp_d[8];
    bit          trig;
    exp_d = '{32'h10, 32'h11, 32'h30, 32'h31,
              32'h12, 32'h13, 32'h32, 32'h33};
    trig = 1'b0;
    do_reset();
    prj_en_mask = 4'b1010;
    for (int i = 0; i < NP; i++)
      for (int p = 0; p < 3; p++) add_pkt(i, 2, i * 16 + p * 2);
    settle();
    for (int c = 0; c < 60; c++) begin
      tick();
      if (!trig && olog.size() >= 4 && arb_busy && cur_grant == 2'd3) begin
        prj_en_mask = 4'b0000;
        settle();
        trig = 1'b1;
      end
    end
    tot_n++;
    if (trig !== 1'b1) $display("FAIL mask_trigger got=%0b exp=1", trig);
    else pass_n++;
    tot_n++;
    if (olog.size() != 8) $display("FAIL mask_count got=%0d exp=8", olog.size());
    else pass_n++;
    for (int k = 0; k < 8 && k < olog.size(); k++) begin
      tot_n++;
      if (olog[k].d !== exp_d[k])
        $display("FAIL mask_beat%0d got=%h exp=%h", k, olog[k].d, exp_d[k]);
      else pass_n++;
    end
    tot_n++;
    if (arb_busy !== 1'b0 || a_sm_tvalid !== 1'b0 || q[1].size() != 2)
      $display("FAIL mask_idle got busy=%0b v=%0b q1=%0d exp=0/0/2",
               arb_busy, a_sm_tvalid, q[1].size());
    else pass_n++;
  endtask

  task automatic test_stall();
    logic [31:0] exp_d[5];
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21};
    do_reset();
    add_pkt(1, 3, 'h10);
    add_pkt(2, 2, 'h20);
    settle();
    for (int c = 0; c < 20 && q[1].size() != 2; c++) tick();
    tot_n++;
    if (q[1].size() != 2 || cur_grant !== 2'd1)
      $display("FAIL stall_start got q1=%0d g=%0d exp=2/1", q[1].size(), cur_grant);
    else pass_n++;
    hold[1] = 1'b1;
    settle();
    for (int c = 0; c < 5; c++) begin
      tick();
      tot_n++;
      if (cur_grant !== 2'd1 || sm_tready[2] !== 1'b0 || arb_busy !== 1'b1)
        $display("FAIL stall_lock c=%0d got g=%0d r2=%0b busy=%0b exp=1/0/1",
                 c, cur_grant, sm_tready[2], arb_busy);
      else pass_n++;
    end
    hold[1] = 1'b0;
    settle();
    for (int c = 0; c < 30 && olog.size() < 5; c++) tick();
    tot_n++;
    if (olog.size() != 5) $display("FAIL stall_count got=%0d exp=5", olog.size());
    else pass_n++;
    for (int k = 0; k < 5 && k < olog.size(); k++) begin
      tot_n++;
      if (olog[k].d !== exp_d[k])
        $display("FAIL stall_beat%0d got=%h exp=%h", k, olog[k].d, exp_d[k]);
      else pass_n++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_pkt(0, 4, 'h00);
    add_pkt(1, 2, 'h10);
    settle();
    for (int c = 0; c < 20 && olog.size() < 1; c++) tick();
    tot_n++;
    if (arb_busy !== 1'b1 || a_sm_tvalid !== 1'b1)
      $display("FAIL rmid_pre got busy=%0b v=%0b exp=1/1", arb_busy, a_sm_tvalid);
    else pass_n++;
    #2;
    ARESET = 1'b1;
    #1;
    tot_n++;
    if (a_sm_tvalid !== 1'b0 || a_sm_tdata !== 32'h0 || a_sm_tlast !== 1'b0 ||
        a_sm_tid !== 3'd0 || sm_tready !== 4'b0)
      $display("FAIL rmid_out got v=%0b d=%h l=%0b id=%0d r=%b exp all 0",
               a_sm_tvalid, a_sm_tdata, a_sm_tlast, a_sm_tid, sm_tready);
    else pass_n++;
    tot_n++;
    if (arb_busy !== 1'b0 || cur_grant !== 2'd3)
      $display("FAIL rmid_state got busy=%0b g=%0d exp=0/3", arb_busy, cur_grant);
    else pass_n++;
    for (int i = 0; i < NP; i++) q[i].delete();
    olog.delete();
    add_pkt(0, 2, 'h40);
    add_pkt(1, 2, 'h50);
    @(negedge ASCLK);
    ARESET = 1'b0;
    settle();
    tick();
    tot_n++;
    if (cur_grant !== 2'd0 || arb_busy !== 1'b1)
      $display("FAIL rmid_regrant got g=%0d busy=%0b exp=0/1", cur_grant, arb_busy);
    else pass_n++;
    for (int c = 0; c < 20 && olog.size() < 2; c++) tick();
    tot_n++;
    if (olog.size() < 2 || olog[0].d !== 32'h40 || olog[1].d !== 32'h41)
      $display("FAIL rmid_beats got n=%0d exp 40,41 first", olog.size());
    else pass_n++;
  endtask

  initial begin
    ARESET      = 1'b1;
    a_sm_tready = 1'b1;
    prj_en_mask = '1;
    sm_tvalid   = '0;
    sm_tdata    = '0;
    sm_tstrb    = '1;
    sm_tkeep    = '1;
    sm_tlast    = '0;
    sm_tid      = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_mask();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/axis_prj_arbiter.md
Name: axis_prj_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one AXI-Stream master port among pNUM_PRJ user-project stream sources.
- Sits between the user-project stream outputs and the single upstream AXIS master interface, replacing static select-based muxing.
- Grants one source per packet and holds the grant until that source's tlast beat is accepted.
- A registered output stage gives full throughput; an enable mask lets software exclude projects.

Parameters:
- pDATA_WIDTH, 32, tdata width.
- pNUM_PRJ, 4, number of requesting sources (2..8).
- pID_WIDTH, 3, tid width.
- pSTRB_WIDTH, 4, tstrb width (pDATA_WIDTH/8).

Ports:
- ASCLK  in  1  stream clock.
- ARESET  in  1  asynchronous, active-high reset.
- prj_en_mask  in  pNUM_PRJ  per-source arbitration enable; bit i=0 excludes source i.
- sm_tvalid  in  pNUM_PRJ  per-source valid.
- sm_tdata  in  pNUM_PRJ*pDATA_WIDTH  flattened data; source i at [i*pDATA_WIDTH +: pDATA_WIDTH].
- sm_tstrb  in  pNUM_PRJ*pSTRB_WIDTH  flattened strobe.
- sm_tkeep  in  pNUM_PRJ  per-source keep.
- sm_tlast  in  pNUM_PRJ  per-source last.
- sm_tid  in  pNUM_PRJ*pID_WIDTH  flattened id.
- sm_tready  out  pNUM_PRJ  per-source ready.
- a_sm_tvalid  out  1  master valid.
- a_sm_tdata  out  pDATA_WIDTH  master data.
- a_sm_tstrb  out  pSTRB_WIDTH  master strobe.
- a_sm_tkeep  out  1  master keep.
- a_sm_tlast  out  1  master last.
- a_sm_tid  out  pID_WIDTH  master id.
- a_sm_tready  in  1  master ready.
- cur_grant  out  $clog2(pNUM_PRJ)  currently or last granted source index.
- arb_busy  out  1  high while a packet is locked.

Behaviour:
- Reset:
  - All a_sm_* outputs are 0. sm_tready is 0.
  - cur_grant = pNUM_PRJ-1, so source 0 has highest priority first. arb_busy = 0. State is IDLE.
  - Reset mid-packet aborts the packet: the output stage is cleared and the partial beat is discarded.
- States:
  - IDLE: sm_tready = 0. req = sm_tvalid & prj_en_mask. If req != 0, select the first set bit scanning cur_grant+1, cur_grant+2, ... (mod pNUM_PRJ). Register it into cur_grant and go to BUSY next cycle. If req == 0, stay in IDLE.
  - BUSY: only the granted source sees ready, so sm_tready[cur_grant] = out_ready and all other bits are 0.
    - A beat is accepted when sm_tvalid[g] & sm_tready[g].
    - Accepting a beat with sm_tlast[g]=1 returns to IDLE at the next edge; cur_grant keeps g.
- Output stage: single register.
  - out_ready = !a_sm_tvalid | a_sm_tready.
  - On an accepted beat, load the granted source's data/strb/keep/last/id and set a_sm_tvalid=1.
  - Otherwise, if a_sm_tready=1, clear a_sm_tvalid.
  - a_sm_* stays stable while a_sm_tvalid=1 and a_sm_tready=0.
- Latency: source tvalid rising in IDLE gives a_sm_tvalid 2 cycles later (1 arbitration cycle, 1 output register).
  - Steady state inside a packet is 1 beat per cycle when a_sm_tready is held high.
  - One idle bubble occurs between packets (the IDLE cycle).
- Boundaries:
  - A granted source dropping tvalid mid-packet keeps the lock with no timeout; other sources wait.
  - Clearing the granted source's mask bit mid-packet does not break the lock. The mask is sampled only in IDLE.
  - Simultaneous requests resolve by round-robin order only; there is no fixed priority.
  - A single-beat packet (tlast on the first beat) gives BUSY for exactly 1 accepted beat.
  - Wrap-around: grant after pNUM_PRJ-1 scans from 0.
  - If all mask bits are 0, stay in IDLE indefinitely with outputs idle.
  - a_sm_tready held low fills the output register; the granted source then sees sm_tready=0 until it drains.
- arb_busy = (state == BUSY).

Decomposition:
- Shared package holds:
  - The state enum {IDLE, BUSY}.
  - A function for the grant index width, $clog2(pNUM_PRJ).
- Sub-module rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector, last-grant index.
  - Outputs: grant index and a valid flag.
  - It is reused by other arbiters in the design.

Test Plan:
- Single source: source 0 sends 3 beats 0xA0,0xA1,0xA2 (tlast on the 3rd) with a_sm_tready=1 → a_sm_tvalid first high 2 cycles after sm_tvalid[0]; beats appear back to back; cur_grant=0; arb_busy falls after the tlast accept.
- Contention: sources 0..3 all hold 2-beat packets from reset → packets emerge in order 0,1,2,3,0 with one bubble between packets and no interleaving of beats.
- Backpressure: a_sm_tready toggles 1,0,0,1 during a 4-beat packet from source 2 → no beat lost or duplicated; a_sm_* stable while stalled; sm_tready[2]=0 while the register is full.
- Mask: prj_en_mask=4'b1010 with all sources valid → only sources 1 and 3 granted, alternating. Set the mask to 0 mid-packet of source 3 → that packet completes; then no further grants.
- Stall inside packet: source 1 drops tvalid for 5 cycles between beats 1 and 2 while source 2 is valid → cur_grant stays 1 and sm_tready[2] stays 0 until source 1's tlast is accepted.
- Reset mid-packet: assert ARESET during beat 2 of a source 0 packet → all outputs 0 immediately (asynchronous); after release, source 0 is granted first again (cur_grant reset to pNUM_PRJ-1).
